// File: rtl/alu_req_arbiter_if.sv
// Bus bundle for alu_req_arbiter: two requester channels, the shared ALU
// operand/result port and the response channel.
// slave modport is the arbiter's view; master modport is the surrounding
// logic (requesters, ALU and response consumer).
interface alu_req_arbiter_if #(
  parameter int unsigned WIDTH = 5
);

  // Requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;

  // Requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;

  // Shared ALU
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cf;
  logic             alu_sf;
  logic             alu_zf;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_cf, alu_sf, alu_zf,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_cf, alu_sf, alu_zf,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    output rsp_ready
  );

endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Sequence per operation: IDLE (grant + operand capture) -> EXEC (ALU settles,
// result captured) -> RESP (hold response until consumer accepts).
// Optional feature macro: ALU_GRANT_COUNT_EN adds saturating 8-bit per-requester
// grant counters on grant_cnt0_o / grant_cnt1_o.
module alu_req_arbiter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  alu_req_arbiter_if.slave        bus_io,
`ifdef ALU_GRANT_COUNT_EN
  output logic [7:0]              grant_cnt0_o,
  output logic [7:0]              grant_cnt1_o,
`endif
  output logic                    busy_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_op_q, alu_op_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_flags_q, rsp_flags_d;

  logic idle;
  logic gnt0;
  logic gnt1;

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    idle = (state_q == StIdle);
    gnt0 = idle & bus_io.req0_valid & (~bus_io.req1_valid | last_grant_q);
    gnt1 = idle & bus_io.req1_valid & (~bus_io.req0_valid | ~last_grant_q);
  end

  // Next-state and datapath capture for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          state_d      = StExec;
          last_grant_d = gnt1;
          rsp_id_d     = gnt1;
          alu_a_d      = gnt1 ? bus_io.req1_a  : bus_io.req0_a;
          alu_b_d      = gnt1 ? bus_io.req1_b  : bus_io.req0_b;
          alu_op_d     = gnt1 ? bus_io.req1_op : bus_io.req0_op;
        end
      end
      StExec: begin
        // Operands have been stable on the ALU for a full cycle here.
        rsp_result_d = bus_io.alu_result;
        rsp_flags_d  = {bus_io.alu_cf, bus_io.alu_sf, bus_io.alu_zf};
        state_d      = StResp;
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured operand/response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // Output drive; ready is combinational so the grant completes in one cycle.
  always_comb begin
    bus_io.req0_ready = gnt0;
    bus_io.req1_ready = gnt1;
    bus_io.alu_a      = alu_a_q;
    bus_io.alu_b      = alu_b_q;
    bus_io.alu_op     = alu_op_q;
    bus_io.rsp_valid  = (state_q == StResp);
    bus_io.rsp_id     = rsp_id_q;
    bus_io.rsp_result = rsp_result_q;
    bus_io.rsp_flags  = rsp_flags_q;
    busy_o            = ~idle;
  end

`ifdef ALU_GRANT_COUNT_EN
  logic [7:0] grant_cnt0_q;
  logic [7:0] grant_cnt1_q;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (gnt0 && (grant_cnt0_q != 8'hff)) begin
        grant_cnt0_q <= grant_cnt0_q + 8'd1;
      end
      if (gnt1 && (grant_cnt1_q != 8'hff)) begin
        grant_cnt1_q <= grant_cnt1_q + 8'd1;
      end
    end
  end

  assign grant_cnt0_o = grant_cnt0_q;
  assign grant_cnt1_o = grant_cnt1_q;
`endif

  // Grants are exclusive and only issued from IDLE.
  a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni) !(gnt0 && gnt1));
  a_grant_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (gnt0 || gnt1) |-> (state_q == StIdle));

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter. A small ALU model drives the result
// port; a monitor pushes expected responses into a scoreboard on every accept
// and the scenario tasks pop and compare when a response is presented.
module tb_alu_req_arbiter;

  localparam int unsigned W = 5;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic [2:0]   flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef ALU_GRANT_COUNT_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t sb[$];
  int   acc_id[$];
  int   acc_cyc[$];

  alu_req_arbiter_if #(.WIDTH(W)) bus ();

  alu_req_arbiter #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus_io       (bus.slave),
`ifdef ALU_GRANT_COUNT_EN
    .grant_cnt0_o (grant_cnt0),
    .grant_cnt1_o (grant_cnt1),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU: add/sub with carry/borrow, sign and zero flags.
  logic [W:0] alu_w;
  always_comb begin
    alu_w = bus.alu_op ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                       : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
  end
  assign bus.alu_result = alu_w[W-1:0];
  assign bus.alu_cf     = alu_w[W];
  assign bus.alu_sf     = alu_w[W-1];
  assign bus.alu_zf     = (alu_w[W-1:0] == '0);

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op);
    logic [W:0] w;
    exp_t e;
    w = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    e.id     = id;
    e.result = w[W-1:0];
    e.flags  = {w[W], w[W-1], (w[W-1:0] == '0)};
    return e;
  endfunction

  // Accept monitor: record expected response, grant id and accept cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req0_valid && bus.req0_ready) begin
      sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
      acc_id.push_back(0);
      acc_cyc.push_back(cyc);
    end
    if (bus.req1_valid && bus.req1_ready) begin
      sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_op));
      acc_id.push_back(1);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic set_req(input int id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic op);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  // Advance to the next negedge (+1) until rsp_valid, bounded.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs [10];
    string nm [10];
    #2;
    obs[0] = 32'(busy);           nm[0] = "reset_busy";
    obs[1] = 32'(bus.rsp_valid);  nm[1] = "reset_rsp_valid";
    obs[2] = 32'(bus.rsp_id);     nm[2] = "reset_rsp_id";
    obs[3] = 32'(bus.rsp_result); nm[3] = "reset_rsp_result";
    obs[4] = 32'(bus.rsp_flags);  nm[4] = "reset_rsp_flags";
    obs[5] = 32'(bus.alu_a);      nm[5] = "reset_alu_a";
    obs[6] = 32'(bus.alu_b);      nm[6] = "reset_alu_b";
    obs[7] = 32'(bus.alu_op);     nm[7] = "reset_alu_op";
    obs[8] = 32'(bus.req0_ready); nm[8] = "reset_req0_ready";
    obs[9] = 32'(bus.req1_ready); nm[9] = "reset_req1_ready";
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== 32'd0) begin
        failures++;
        $display("FAIL %s got=%0h exp=0", nm[i], obs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic op, input logic [W-1:0] lit_res,
                                input logic [2:0] lit_flags);
    exp_t e;
    logic rdy_me;
    logic rdy_other;
    @(negedge clk);
    set_req(id, 1'b1, a, b, op);
    bus.rsp_ready = 1'b1;
    #1;
    rdy_me    = (id == 0) ? bus.req0_ready : bus.req1_ready;
    rdy_other = (id == 0) ? bus.req1_ready : bus.req0_ready;
    checks++;
    if (rdy_me !== 1'b1 || rdy_other !== 1'b0) begin
      failures++;
      $display("FAIL single_ready id=%0d got=%b/%b exp=1/0", id, rdy_me, rdy_other);
    end
    // Cycle 1: EXEC
    @(negedge clk);
    set_req(id, 1'b0, a, b, op);
    #1;
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_exec busy=%b rsp_valid=%b exp=1/0", busy, bus.rsp_valid);
    end
    checks++;
    if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_op !== op) begin
      failures++;
      $display("FAIL single_alu_in got=%0d/%0d/%b exp=%0d/%0d/%b",
               bus.alu_a, bus.alu_b, bus.alu_op, a, b, op);
    end
    // Cycle 2: RESP
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency rsp_valid got=%b exp=1", bus.rsp_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL single_sb no accept recorded got=0 exp=1");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {e.id, e.result, e.flags}) begin
        failures++;
        $display("FAIL single_rsp got=id%0d res%0d fl%b exp=id%0d res%0d fl%b",
                 bus.rsp_id, bus.rsp_result, bus.rsp_flags, e.id, e.result, e.flags);
      end
    end
    checks++;
    if (bus.rsp_id !== 1'(id) || bus.rsp_result !== lit_res || bus.rsp_flags !== lit_flags) begin
      failures++;
      $display("FAIL single_literal got=id%0d res%0d fl%b exp=id%0d res%0d fl%b",
               bus.rsp_id, bus.rsp_result, bus.rsp_flags, id, lit_res, lit_flags);
    end
    // Back in IDLE, operands retained
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.alu_a !== a) begin
      failures++;
      $display("FAIL single_done rsp_valid=%b busy=%b alu_a=%0d exp=0/0/%0d",
               bus.rsp_valid, busy, bus.alu_a, a);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    acc_id.delete();
    acc_cyc.delete();
    @(negedge clk);
    set_req(0, 1'b1, 5'd10, 5'd3, 1'b0);
    set_req(1, 1'b1, 5'd2, 5'd9, 1'b1);
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_rsp(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL b2b_timeout op=%0d got=no_rsp exp=rsp", n);
        break;
      end
      if (n == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      if (bus.rsp_id !== 1'(n % 2)) begin
        failures++;
        $display("FAIL b2b_order op=%0d got=%0d exp=%0d", n, bus.rsp_id, n % 2);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL b2b_sb op=%0d got=empty exp=entry", n);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {e.id, e.result, e.flags}) begin
          failures++;
          $display("FAIL b2b_rsp op=%0d got=id%0d res%0d fl%b exp=id%0d res%0d fl%b", n,
                   bus.rsp_id, bus.rsp_result, bus.rsp_flags, e.id, e.result, e.flags);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (acc_id.size() != 4 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d accepts,%0d pending exp=4,0", acc_id.size(), sb.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          failures++;
          $display("FAIL b2b_interval i=%0d got=%0d exp=3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 5'd31, 5'd1, 1'b0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    set_req(0, 1'b0, 5'd31, 5'd1, 1'b0);
    set_req(1, 1'b1, 5'd7, 5'd2, 1'b1);
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL bp_rsp got=ok%0d sb%0d exp=ok1 sb1", ok, sb.size());
      e = '0;
    end else begin
      e = sb.pop_front();
      if (e.flags !== 3'b101 || bus.rsp_id !== 1'b0) begin
        failures++;
        $display("FAIL bp_first got=id%0d fl%b exp=id0 fl101", bus.rsp_id, e.flags);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e.result || bus.rsp_flags !== e.flags ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=v%b res%0d fl%b rdy%b%b exp=v1 res%0d fl%b rdy00", i,
                 bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.req0_ready, bus.req1_ready,
                 e.result, e.flags);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got=v%b busy%b rdy1%b exp=v0 busy0 rdy1_1",
               bus.rsp_valid, busy, bus.req1_ready);
    end
    @(negedge clk);
    set_req(1, 1'b0, 5'd7, 5'd2, 1'b1);
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL bp_second got=ok%0d sb%0d exp=ok1 sb1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {e.id, e.result, e.flags}) begin
        failures++;
        $display("FAIL bp_second_rsp got=id%0d res%0d fl%b exp=id%0d res%0d fl%b",
                 bus.rsp_id, bus.rsp_result, bus.rsp_flags, e.id, e.result, e.flags);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 5'd6, 5'd1, 1'b0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 5'd6, 5'd1, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_exec busy got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.alu_a, bus.alu_b,
         bus.alu_op, bus.req0_ready, bus.req1_ready} !== '0) begin
      failures++;
      $display("FAIL rstmid_zero got=busy%b v%b id%b res%0d fl%b a%0d b%0d op%b exp=all0",
               busy, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.alu_a,
               bus.alu_b, bus.alu_op);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_norsp cyc=%0d got=v%b busy%b exp=0/0", i, bus.rsp_valid, busy);
      end
    end
    set_req(0, 1'b1, 5'd1, 5'd1, 1'b0);
    set_req(1, 1'b1, 5'd2, 5'd2, 1'b0);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_grant got=rdy%b%b exp=rdy10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL rstmid_rsp got=ok%0d sb%0d exp=ok1 sb1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {e.id, e.result, e.flags}) begin
        failures++;
        $display("FAIL rstmid_rsp_val got=id%0d res%0d fl%b exp=id%0d res%0d fl%b",
                 bus.rsp_id, bus.rsp_result, bus.rsp_flags, e.id, e.result, e.flags);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_grant_count();
`ifdef ALU_GRANT_COUNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL cnt_reset got=%0d/%0d exp=0/0", grant_cnt0, grant_cnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'd1, 5'd2, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (300 * 3) @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL cnt_saturate got=%0d/%0d exp=255/0", grant_cnt0, grant_cnt1);
    end
    sb.delete();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 1'b0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_single_op(0, 5'd3, 5'd4, 1'b0, 5'd7, 3'b000);
    test_single_op(1, 5'd5, 5'd5, 1'b1, 5'd0, 3'b001);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_grant_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one combinational ALU between two requesters using a round-robin arbiter and a small sequencing FSM. Each requester presents an operand pair plus an op bit on a valid/ready handshake. The block drives the ALU from registered operands, captures result and flags, and returns them on a response channel tagged with the requester id. It sits between the test/controller logic and the ALU datapath inside top-level integrations.

Parameters:
WIDTH, 5, operand/result width in bits; must match the ALU.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_op  in  1  requester 0 op select (0 add, 1 sub)
req1_valid, req1_ready, req1_a, req1_b, req1_op  (same as requester 0, for requester 1)
alu_a  out  WIDTH  ALU operand A (registered)
alu_b  out  WIDTH  ALU operand B (registered)
alu_op  out  1  ALU op select (registered)
alu_result  in  WIDTH  ALU result
alu_cf  in  1  ALU carry flag
alu_sf  in  1  ALU sign flag
alu_zf  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_id  out  1  requester that owns the response
rsp_result  out  WIDTH  captured ALU result
rsp_flags  out  3  captured flags: [2]=CF, [1]=SF, [0]=ZF
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, last_grant=1 so requester 0 wins first. All outputs 0: alu_a, alu_b, alu_op, rsp_*, busy, req*_ready.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If either valid is high, grant one requester. reqN_ready=1 (combinational) only for the granted requester, in the same cycle.
  - Latch its a/b/op into alu_a/alu_b/alu_op and its id into rsp_id, update last_grant, go to EXEC.
  - Nothing valid: stay in IDLE; ready outputs stay 0.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins, so simultaneous streams strictly alternate.
- EXEC (one cycle): ALU inputs are stable. At the cycle end, register alu_result into rsp_result and {alu_cf, alu_sf, alu_zf} into rsp_flags, then go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_flags are held stable.
  - When rsp_valid and rsp_ready are both high, go to IDLE. rsp_valid drops the next cycle.
  - rsp_ready may be held low indefinitely; the outputs stay frozen.
- Timing:
  - Accept-to-rsp_valid latency: 2 cycles.
  - Minimum issue interval: 3 cycles (accept, exec, resp with rsp_ready=1).
- Ready is never asserted outside IDLE; valids seen in EXEC/RESP are ignored until the next IDLE.
- alu_a/alu_b/alu_op keep the last operation's values after completion; they change only on a new grant.
- Arithmetic is performed entirely by the ALU. This block does no width extension; captured values are passed through unmodified.
- Reset mid-operation returns immediately to the reset state. The in-flight operation is dropped and no response is produced.
- busy=1 in EXEC and RESP.

Optional Feature:
ALU_GRANT_COUNT_EN:
- Defined: adds outputs grant_cnt0 and grant_cnt1 (8 bits each). Each counts accepted grants for its requester, saturates at 255, and clears on reset.
- Undefined: the ports and logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset then req0 {a=3, b=4, op=0}, rsp_ready=1 -> req0_ready pulses in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_result=7, rsp_flags=3'b000.
- req1 {a=5, b=5, op=1} -> rsp_id=1, rsp_result=0, ZF=1 (rsp_flags[0]=1).
- Both valid continuously, rsp_ready=1, 4 operations -> grant order 0, 1, 0, 1; issue interval exactly 3 cycles.
- rsp_ready held low 4 cycles in RESP -> rsp_valid, rsp_result and rsp_flags stable; no req*_ready asserted; IDLE reached the cycle after rsp_ready rises.
- Assert reset during EXEC -> all outputs 0 immediately; no response emitted; the next grant goes to req0.
- With ALU_GRANT_COUNT_EN: 300 req0-only operations -> grant_cnt0=255 and grant_cnt1=0.
